// File: rtl/cmp_result_debounce.sv
// Debounce filter for the 4-bit magnitude comparator's one-hot relation flags.
// A new relation is committed only after HOLD consecutive agreeing valid samples;
// it also tracks GT<->LT crossings and flags malformed (non one-hot) samples.
module cmp_result_debounce #(
   parameter int unsigned HOLD  = 3,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             sample_valid,
   input  logic             A_eq_B,
   input  logic             A_gt_B,
   input  logic             A_lt_B,
   output logic             rel_eq,
   output logic             rel_gt,
   output logic             rel_lt,
   output logic             rel_valid,
   output logic             rel_change,
   output logic [CNT_W-1:0] cross_count,
   output logic             onehot_err
);

   // RelNone doubles as INIT for the committed relation and NONE for the candidate
   typedef enum logic [1:0] {
      RelNone = 2'd0,
      RelEq   = 2'd1,
      RelGt   = 2'd2,
      RelLt   = 2'd3
   } rel_e;

   localparam logic [3:0]       HoldCnt  = 4'(HOLD);
   localparam logic [CNT_W-1:0] CrossMax = '1;

   rel_e             r_comm, w_comm_d;
   rel_e             r_cand, w_cand_d;
   logic [3:0]       r_run, w_run_d;
   logic             r_valid, w_valid_d;
   logic             r_change, w_change_d;
   logic [CNT_W-1:0] r_cross, w_cross_d;
   logic             r_err, w_err_d;

   rel_e             w_rel;
   logic             w_onehot;
   logic             w_commit;
   logic [3:0]       w_run_inc;

   assign w_run_inc = r_run + 4'd1;

   // Decode the comparator flags; anything other than exactly one set is malformed
   always_comb begin
      w_rel    = RelNone;
      w_onehot = 1'b0;
      case ({A_eq_B, A_gt_B, A_lt_B})
         3'b100:  begin w_rel = RelEq; w_onehot = 1'b1; end
         3'b010:  begin w_rel = RelGt; w_onehot = 1'b1; end
         3'b001:  begin w_rel = RelLt; w_onehot = 1'b1; end
         default: ;
      endcase
   end

   // Next-state: run tracking, commit, crossing count and sticky error
   always_comb begin
      w_comm_d   = r_comm;
      w_cand_d   = r_cand;
      w_run_d    = r_run;
      w_valid_d  = r_valid;
      w_change_d = 1'b0;
      w_cross_d  = r_cross;
      w_err_d    = r_err;
      w_commit   = 1'b0;

      if (clear) begin
         w_comm_d  = RelNone;
         w_cand_d  = RelNone;
         w_run_d   = 4'd0;
         w_valid_d = 1'b0;
         w_cross_d = '0;
         w_err_d   = 1'b0;
      end else if (sample_valid) begin
         if (!w_onehot) begin
            w_err_d = 1'b1;
         end else if (w_rel == r_comm) begin
            // Agreement with what is already committed cancels any pending change
            w_cand_d = RelNone;
            w_run_d  = 4'd0;
         end else if (w_rel == r_cand) begin
            if (w_run_inc >= HoldCnt) begin
               w_commit = 1'b1;
            end else begin
               w_run_d = w_run_inc;
            end
         end else if (HoldCnt == 4'd1) begin
            w_commit = 1'b1;
         end else begin
            w_cand_d = w_rel;
            w_run_d  = 4'd1;
         end

         if (w_commit) begin
            w_comm_d   = w_rel;
            w_cand_d   = RelNone;
            w_run_d    = 4'd0;
            w_valid_d  = 1'b1;
            w_change_d = 1'b1;
            if (((r_comm == RelGt) && (w_rel == RelLt)) ||
                ((r_comm == RelLt) && (w_rel == RelGt))) begin
               if (r_cross != CrossMax) begin
                  w_cross_d = r_cross + 1'b1;
               end
            end
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_comm   <= RelNone;
         r_cand   <= RelNone;
         r_run    <= 4'd0;
         r_valid  <= 1'b0;
         r_change <= 1'b0;
         r_cross  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_comm   <= w_comm_d;
         r_cand   <= w_cand_d;
         r_run    <= w_run_d;
         r_valid  <= w_valid_d;
         r_change <= w_change_d;
         r_cross  <= w_cross_d;
         r_err    <= w_err_d;
      end
   end

   assign rel_eq      = (r_comm == RelEq);
   assign rel_gt      = (r_comm == RelGt);
   assign rel_lt      = (r_comm == RelLt);
   assign rel_valid   = r_valid;
   assign rel_change  = r_change;
   assign cross_count = r_cross;
   assign onehot_err  = r_err;

endmodule

// File: tb/tb_cmp_result_debounce.sv
// Self-checking bench: a HOLD=3 and a HOLD=1 instance share one stimulus stream.
// The reference model tracks the streak of identical one-hot samples.
module tb_cmp_result_debounce;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic sample_valid = 1'b0;
   logic A_eq_B = 1'b0, A_gt_B = 1'b0, A_lt_B = 1'b0;

   logic o3_eq, o3_gt, o3_lt, o3_valid, o3_change, o3_err;
   logic o1_eq, o1_gt, o1_lt, o1_valid, o1_change, o1_err;
   logic [7:0] o3_cross, o1_cross;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cmp_result_debounce #(.HOLD(3), .CNT_W(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .sample_valid(sample_valid),
      .A_eq_B(A_eq_B), .A_gt_B(A_gt_B), .A_lt_B(A_lt_B),
      .rel_eq(o3_eq), .rel_gt(o3_gt), .rel_lt(o3_lt), .rel_valid(o3_valid),
      .rel_change(o3_change), .cross_count(o3_cross), .onehot_err(o3_err)
   );

   cmp_result_debounce #(.HOLD(1), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .sample_valid(sample_valid),
      .A_eq_B(A_eq_B), .A_gt_B(A_gt_B), .A_lt_B(A_lt_B),
      .rel_eq(o1_eq), .rel_gt(o1_gt), .rel_lt(o1_lt), .rel_valid(o1_valid),
      .rel_change(o1_change), .cross_count(o1_cross), .onehot_err(o1_err)
   );

   // Reference model: relation codes 0=none/init, 1=EQ, 2=GT, 3=LT
   int m_comm[2], m_last[2], m_n[2], m_cross[2];
   bit m_err[2], m_chg[2];
   int holds[2] = '{3, 1};

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_comm[i] = 0; m_last[i] = 0; m_n[i] = 0; m_cross[i] = 0;
         m_err[i] = 1'b0; m_chg[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      int ones, r;
      ones = int'(A_eq_B) + int'(A_gt_B) + int'(A_lt_B);
      r = A_eq_B ? 1 : (A_gt_B ? 2 : 3);
      for (int i = 0; i < 2; i++) begin
         m_chg[i] = 1'b0;
         if (clear) begin
            m_comm[i] = 0; m_last[i] = 0; m_n[i] = 0; m_cross[i] = 0; m_err[i] = 1'b0;
         end else if (sample_valid) begin
            if (ones != 1) begin
               m_err[i] = 1'b1;
            end else begin
               if (r == m_last[i]) m_n[i]++;
               else begin m_last[i] = r; m_n[i] = 1; end
               if (r != m_comm[i] && m_n[i] >= holds[i]) begin
                  if ((m_comm[i] == 2 && r == 3) || (m_comm[i] == 3 && r == 2))
                     m_cross[i] = (m_cross[i] < 255) ? m_cross[i] + 1 : 255;
                  m_comm[i] = r;
                  m_chg[i] = 1'b1;
               end
            end
         end
      end
   endtask

   function automatic logic [13:0] exp_vec(int i);
      return {m_comm[i] != 0, m_comm[i] == 1, m_comm[i] == 2, m_comm[i] == 3,
              m_chg[i], m_err[i], 8'(m_cross[i])};
   endfunction

   function automatic logic [13:0] act_vec(int i);
      if (i == 0) return {o3_valid, o3_eq, o3_gt, o3_lt, o3_change, o3_err, o3_cross};
      return {o1_valid, o1_eq, o1_gt, o1_lt, o1_change, o1_err, o1_cross};
   endfunction

   // One clock: drive inputs, let the edge happen, sample 1 time unit later
   task automatic cycle(input logic v, input logic e, input logic g, input logic l,
                        input logic c);
      sample_valid = v; A_eq_B = e; A_gt_B = g; A_lt_B = l; clear = c;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #3;
      checks++;
      if (act_vec(0) !== 14'd0) begin
         failures++; $display("FAIL reset_dut3: got %h expected 0", act_vec(0));
      end
      checks++;
      if (act_vec(1) !== 14'd0) begin
         failures++; $display("FAIL reset_dut1: got %h expected 0", act_vec(1));
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_commit_latency();
      for (int k = 0; k < 2; k++) begin
         cycle(1, 0, 1, 0, 0);
         checks++;
         if ({o3_valid, o3_gt, o3_change} !== 3'b000) begin
            failures++;
            $display("FAIL early_commit: sample %0d got %b expected 000", k,
                     {o3_valid, o3_gt, o3_change});
         end
      end
      cycle(1, 0, 1, 0, 0);
      checks++;
      if ({o3_valid, o3_eq, o3_gt, o3_lt, o3_change} !== 5'b10101) begin
         failures++;
         $display("FAIL commit_gt: got %b expected 10101",
                  {o3_valid, o3_eq, o3_gt, o3_lt, o3_change});
      end
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (o3_change !== 1'b0) begin
         failures++; $display("FAIL change_one_cycle: got %b expected 0", o3_change);
      end
   endtask

   task automatic test_interrupted();
      int pulses = 0;
      logic [2:0] seq [6] = '{3'b001, 3'b001, 3'b100, 3'b001, 3'b001, 3'b001};
      for (int k = 0; k < 6; k++) begin
         cycle(1, seq[k][2], seq[k][1], seq[k][0], 0);
         pulses += int'(o3_change);
         if (k < 5) begin
            checks++;
            if (o3_gt !== 1'b1) begin
               failures++; $display("FAIL interrupted_hold: step %0d rel_gt=%b expected 1", k, o3_gt);
            end
         end
      end
      checks++;
      if ({o3_gt, o3_lt} !== 2'b01) begin
         failures++; $display("FAIL interrupted_commit: gt/lt=%b expected 01", {o3_gt, o3_lt});
      end
      checks++;
      if (o3_cross !== 8'd1) begin
         failures++; $display("FAIL cross_once: got %0d expected 1", o3_cross);
      end
      checks++;
      if (pulses != 1) begin
         failures++; $display("FAIL single_pulse: got %0d expected 1", pulses);
      end
   endtask

   task automatic test_onehot_err();
      cycle(0, 0, 0, 0, 1);
      cycle(1, 1, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
      checks++;
      if ({o3_err, o3_valid} !== 2'b00) begin
         failures++; $display("FAIL err_before: got %b expected 00", {o3_err, o3_valid});
      end
      cycle(1, 0, 1, 1, 0);
      checks++;
      if ({o3_err, o3_valid} !== 2'b10) begin
         failures++; $display("FAIL err_set: got %b expected 10", {o3_err, o3_valid});
      end
      cycle(1, 1, 0, 0, 0);
      checks++;
      if ({o3_err, o3_eq, o3_change} !== 3'b111) begin
         failures++; $display("FAIL err_eq_commit: got %b expected 111", {o3_err, o3_eq, o3_change});
      end
      cycle(0, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
      checks++;
      if (o3_err !== 1'b1) begin
         failures++; $display("FAIL err_sticky: got %b expected 1", o3_err);
      end
   endtask

   task automatic test_gaps_clear();
      cycle(0, 0, 0, 0, 1);
      for (int c = 0; c <= 9; c++) begin
         if (c == 0 || c == 5 || c == 9) cycle(1, 0, 1, 0, 0);
         else cycle(0, 1, 0, 1, 0);
         if (c < 9) begin
            checks++;
            if (o3_valid !== 1'b0) begin
               failures++; $display("FAIL gap_early: cycle %0d valid=%b expected 0", c, o3_valid);
            end
         end
      end
      checks++;
      if ({o3_valid, o3_gt, o3_change} !== 3'b111) begin
         failures++; $display("FAIL gap_commit: got %b expected 111", {o3_valid, o3_gt, o3_change});
      end
      cycle(1, 0, 1, 0, 1);
      checks++;
      if (act_vec(0) !== 14'd0) begin
         failures++; $display("FAIL clear_priority: got %h expected 0", act_vec(0));
      end
      cycle(1, 0, 1, 0, 0);
      cycle(1, 0, 1, 0, 0);
      checks++;
      if (o3_valid !== 1'b0) begin
         failures++; $display("FAIL clear_sample_ignored: valid=%b expected 0", o3_valid);
      end
      cycle(1, 0, 1, 0, 0);
      checks++;
      if (o3_gt !== 1'b1) begin
         failures++; $display("FAIL clear_recommit: rel_gt=%b expected 1", o3_gt);
      end
   endtask

   task automatic test_async_reset();
      cycle(1, 0, 0, 1, 0);
      cycle(1, 0, 0, 1, 0);
      checks++;
      if (o3_gt !== 1'b1) begin
         failures++; $display("FAIL pre_reset_state: rel_gt=%b expected 1", o3_gt);
      end
      sample_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (act_vec(0) !== 14'd0) begin
         failures++; $display("FAIL async_reset: got %h expected 0", act_vec(0));
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cycle(1, 0, 0, 1, 0);
         checks++;
         if (o3_valid !== 1'b0) begin
            failures++; $display("FAIL reset_progress_kept: sample %0d valid=%b expected 0", k, o3_valid);
         end
      end
      cycle(1, 0, 0, 1, 0);
      checks++;
      if ({o3_lt, o3_cross} !== {1'b1, 8'd0}) begin
         failures++; $display("FAIL reset_recommit: lt=%b cross=%0d expected lt=1 cross=0", o3_lt, o3_cross);
      end
   endtask

   task automatic test_saturation();
      int bad = 0;
      cycle(0, 0, 0, 0, 1);
      for (int k = 0; k < 300; k++) begin
         cycle(1, 0, k[0] == 1'b0, k[0] == 1'b1, 0);
         if (o1_change !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL sat_change_every_cycle: %0d cycles low, expected 0", bad);
      end
      checks++;
      if (o1_cross !== 8'd255) begin
         failures++; $display("FAIL sat_count: got %0d expected 255", o1_cross);
      end
      cycle(1, 0, 1, 0, 0);
      cycle(1, 0, 0, 1, 0);
      checks++;
      if (o1_cross !== 8'd255) begin
         failures++; $display("FAIL sat_hold: got %0d expected 255", o1_cross);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      int prev = 2;
      logic [2:0] f;
      cycle(0, 0, 0, 0, 1);
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            f = 3'($urandom_range(0, 7));
         end else begin
            if ($urandom_range(0, 3) == 0) prev = int'($urandom_range(0, 2));
            f = 3'b100 >> prev;
         end
         cycle($urandom_range(0, 3) != 0, f[2], f[1], f[0], $urandom_range(0, 99) == 0);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== exp_vec(i)) begin
               failures++;
               if (bad < 10)
                  $display("FAIL random_dut%0d: cycle %0d got %b expected %b",
                           holds[i], k, act_vec(i), exp_vec(i));
               bad++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_commit_latency();
      test_interrupted();
      test_onehot_err();
      test_gaps_clear();
      test_async_reset();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
